// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file -- architectural register file with rename tags.
//
// Holds 2**REG_ID_WIDTH committed values. Each register also holds the ROB id
// of its youngest in-flight producer (0 = value is ready). The issuer reads
// operands combinationally and records new producers at issue. The ROB commits
// values and clears matching tags. A ROB flush clears every tag.
//
// Optional feature (compile-time macro REG_FILE_COMMIT_BYPASS_EN):
//   defined   - a commit that retires a read register's pending producer is
//               forwarded to that read port in the same cycle.
//   undefined - reads return stored state only.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   rdy                         global ready; low freezes all state
//   rs1/rs2_from_issuer         source register indices
//   qj/qk_to_issuer             pending producer tag per source, 0 = ready
//   vj/vk_to_issuer             source values, meaningful when tag is 0
//   valid/rd/dest_from_issuer   issue: register rd gets producer tag dest
//   dest/rd/value_from_rob      commit: dest = 0 means no commit
//   reset_from_rob_bus          mispredict flush, clears all tags
// -----------------------------------------------------------------------------
module reg_file #(
  parameter int XLEN         = 32,
  parameter int REG_ID_WIDTH = 5,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic [REG_ID_WIDTH-1:0] rs1_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rs2_from_issuer,
  output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
  output logic [XLEN-1:0]         vj_to_issuer,
  output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
  output logic [XLEN-1:0]         vk_to_issuer,
  input  logic                    valid_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rd_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
  input  logic [REG_ID_WIDTH-1:0] rd_from_rob,
  input  logic [XLEN-1:0]         value_from_rob,
  input  logic                    reset_from_rob_bus
);

  localparam int NREG = 2 ** REG_ID_WIDTH;

  logic [XLEN-1:0]         values_q [NREG];
  logic [XLEN-1:0]         values_d [NREG];
  logic [ROB_ID_WIDTH-1:0] tags_q   [NREG];
  logic [ROB_ID_WIDTH-1:0] tags_d   [NREG];

  logic commit_en;
  logic issue_en;
  logic flush_en;

  // Writes to x0 are dropped here, so x0 never leaves its reset value.
  assign commit_en = rdy && (dest_from_rob != '0) && (rd_from_rob != '0);
  assign flush_en  = rdy && reset_from_rob_bus;
  assign issue_en  = rdy && valid_from_issuer && (rd_from_issuer != '0) && !reset_from_rob_bus;

  // Next-state. Priority per register: commit clears a matching tag, flush
  // clears all tags, issue sets the tag last so it beats both a same-cycle
  // commit and the stale tag. The commit value is written regardless.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      // NOTE: every combinational output gets a default before any condition,
      // otherwise the tool infers a latch to hold it on the untaken paths.
      values_d[i] = values_q[i];
      tags_d[i]   = tags_q[i];
      if (commit_en && (rd_from_rob == REG_ID_WIDTH'(i))) begin
        values_d[i] = value_from_rob;
        if (tags_q[i] == dest_from_rob) tags_d[i] = '0;
      end
      if (flush_en) tags_d[i] = '0;
      if (issue_en && (rd_from_issuer == REG_ID_WIDTH'(i))) tags_d[i] = dest_from_issuer;
    end
    values_d[0] = '0;
    tags_d[0]   = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is flops, not a RAM macro, and the issuer relies on
      // every tag reading 0 after reset, so the whole array is reset.
      for (int i = 0; i < NREG; i++) begin
        values_q[i] <= '0;
        tags_q[i]   <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      for (int i = 0; i < NREG; i++) begin
        values_q[i] <= values_d[i];
        tags_q[i]   <= tags_d[i];
      end
    end
  end

  // Combinational read ports. Index 0 reads 0 because x0 is never written.
  always_comb begin
    qj_to_issuer = tags_q[rs1_from_issuer];
    vj_to_issuer = values_q[rs1_from_issuer];
    qk_to_issuer = tags_q[rs2_from_issuer];
    vk_to_issuer = values_q[rs2_from_issuer];
`ifdef REG_FILE_COMMIT_BYPASS_EN
    // Forward only when the commit retires the producer the issuer would wait
    // on. A commit from an older producer must not hide a younger pending tag.
    if (commit_en && (rd_from_rob == rs1_from_issuer) &&
        (tags_q[rs1_from_issuer] == dest_from_rob)) begin
      qj_to_issuer = '0;
      vj_to_issuer = value_from_rob;
    end
    if (commit_en && (rd_from_rob == rs2_from_issuer) &&
        (tags_q[rs2_from_issuer] == dest_from_rob)) begin
      qk_to_issuer = '0;
      vk_to_issuer = value_from_rob;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file -- self-checking bench for reg_file.
// Directed scenarios push constant expectations, and a randomized phase pushes
// expectations from a small behavioural model. Expectations go into a queue
// when the read inputs are driven. They are popped and compared when the read
// outputs are sampled. Honors REG_FILE_COMMIT_BYPASS_EN like the design.
// -----------------------------------------------------------------------------
module tb_reg_file;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int TW   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rdy;
  logic [RW-1:0]   rs1, rs2, rd_iss, rd_rob;
  logic [TW-1:0]   qj, qk, dest_iss, dest_rob;
  logic [XLEN-1:0] vj, vk, val_rob;
  logic            valid_iss, flush;

  reg_file #(.XLEN(XLEN), .REG_ID_WIDTH(RW), .ROB_ID_WIDTH(TW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rdy                (rdy),
    .rs1_from_issuer    (rs1),
    .rs2_from_issuer    (rs2),
    .qj_to_issuer       (qj),
    .vj_to_issuer       (vj),
    .qk_to_issuer       (qk),
    .vk_to_issuer       (vk),
    .valid_from_issuer  (valid_iss),
    .rd_from_issuer     (rd_iss),
    .dest_from_issuer   (dest_iss),
    .dest_from_rob      (dest_rob),
    .rd_from_rob        (rd_rob),
    .value_from_rob     (val_rob),
    .reset_from_rob_bus (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [TW-1:0]   qj;
    logic [XLEN-1:0] vj;
    logic [TW-1:0]   qk;
    logic [XLEN-1:0] vk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model for the randomized phase.
  logic [XLEN-1:0] m_val [32];
  logic [TW-1:0]   m_tag [32];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    valid_iss = 1'b0; rd_iss = '0; dest_iss = '0;
    dest_rob  = '0;   rd_rob = '0; val_rob  = '0;
    flush     = 1'b0; rdy    = 1'b1;
  endtask

  // Apply the current control inputs across one rising edge, then go idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic issue(input logic [RW-1:0] rd, input logic [TW-1:0] dest);
    valid_iss = 1'b1; rd_iss = rd; dest_iss = dest;
    step();
  endtask

  task automatic commit(input logic [TW-1:0] dest, input logic [RW-1:0] rd, input logic [XLEN-1:0] v);
    dest_rob = dest; rd_rob = rd; val_rob = v;
    step();
  endtask

  // Drive read indices, queue the expectation, then sample away from the edge.
  task automatic expect_read(input string name, input logic [RW-1:0] a, input logic [RW-1:0] b,
                             input logic [TW-1:0] eqj, input logic [XLEN-1:0] evj,
                             input logic [TW-1:0] eqk, input logic [XLEN-1:0] evk);
    exp_t e;
    rs1 = a; rs2 = b;
    e.name = name; e.qj = eqj; e.vj = evj; e.qk = eqk; e.vk = evk;
    exp_q.push_back(e);
    #1;
    compare_front();
  endtask

  task automatic compare_front();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({e.name, ".qj"}, XLEN'(qj), XLEN'(e.qj));
    check({e.name, ".vj"}, vj, e.vj);
    check({e.name, ".qk"}, XLEN'(qk), XLEN'(e.qk));
    check({e.name, ".vk"}, vk, e.vk);
  endtask

  // Model read including the optional same-cycle commit forwarding.
  function automatic void model_read(input logic [RW-1:0] rs, output logic [TW-1:0] q,
                                     output logic [XLEN-1:0] v);
    q = m_tag[rs];
    v = m_val[rs];
`ifdef REG_FILE_COMMIT_BYPASS_EN
    if (rdy && dest_rob != 0 && rd_rob != 0 && rd_rob == rs && m_tag[rs] == dest_rob) begin
      q = '0;
      v = val_rob;
    end
`endif
  endfunction

  // Model state update at a rising edge, using the inputs held across it.
  task automatic model_update();
    if (!rdy) return;
    if (dest_rob != 0 && rd_rob != 0) begin
      m_val[rd_rob] = val_rob;
      if (m_tag[rd_rob] == dest_rob) m_tag[rd_rob] = '0;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_tag[i] = '0;
    end else if (valid_iss && rd_iss != 0) begin
      m_tag[rd_iss] = dest_iss;
    end
  endtask

  initial begin
    idle_inputs();
    rs1 = '0; rs2 = '0;
    rst_n = 1'b0;
    #12;

    // Reset state, read during reset.
    expect_read("reset", 5'd5, 5'd0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // x0 is immune to commit and issue.
    dest_rob = 4'd1; rd_rob = 5'd0; val_rob = 32'hFFFF_FFFF;
    valid_iss = 1'b1; rd_iss = 5'd0; dest_iss = 4'd3;
    step();
    expect_read("x0", 5'd0, 5'd0, 0, 0, 0, 0);

    // Basic issue then commit.
    issue(5'd3, 4'd7);
    expect_read("issue3", 5'd3, 5'd0, 4'd7, 0, 0, 0);
    commit(4'd7, 5'd3, 32'hDEAD_BEEF);
    expect_read("commit3", 5'd3, 5'd0, 0, 32'hDEAD_BEEF, 0, 0);

    // Older commit keeps the younger tag.
    issue(5'd3, 4'd7);
    issue(5'd3, 4'd9);
    commit(4'd7, 5'd3, 32'h11);
    expect_read("older_commit", 5'd3, 5'd0, 4'd9, 32'h11, 0, 0);
    commit(4'd9, 5'd3, 32'h22);
    expect_read("younger_commit", 5'd3, 5'd0, 0, 32'h22, 0, 0);

    // Same-cycle commit and issue on one register: issue tag wins.
    dest_rob = 4'd4; rd_rob = 5'd8; val_rob = 32'h55;
    valid_iss = 1'b1; rd_iss = 5'd8; dest_iss = 4'd5;
    step();
    expect_read("same_cycle", 5'd0, 5'd8, 0, 0, 4'd5, 32'h55);
    commit(4'd5, 5'd8, 32'h66);
    expect_read("same_cycle_done", 5'd0, 5'd8, 0, 0, 0, 32'h66);

    // Flush with a concurrent commit and a discarded issue.
    issue(5'd1, 4'd2);
    issue(5'd2, 4'd3);
    flush = 1'b1;
    dest_rob = 4'd2; rd_rob = 5'd1; val_rob = 32'hAA;
    valid_iss = 1'b1; rd_iss = 5'd6; dest_iss = 4'd4;
    step();
    expect_read("flush_x1x2", 5'd1, 5'd2, 0, 32'hAA, 0, 0);
    expect_read("flush_x6", 5'd6, 5'd0, 0, 0, 0, 0);

    // Commit bypass on read port 2.
    issue(5'd10, 4'd6);
    dest_rob = 4'd6; rd_rob = 5'd10; val_rob = 32'h1234;
`ifdef REG_FILE_COMMIT_BYPASS_EN
    expect_read("bypass_same", 5'd0, 5'd10, 0, 0, 0, 32'h1234);
`else
    expect_read("bypass_same", 5'd0, 5'd10, 0, 0, 4'd6, 0);
`endif
    step();
    expect_read("bypass_next", 5'd0, 5'd10, 0, 0, 0, 32'h1234);

    // rdy low freezes everything: issue, commit and flush ignored.
    issue(5'd11, 4'd3);
    rdy = 1'b0;
    dest_rob = 4'd3; rd_rob = 5'd11; val_rob = 32'h99;
    valid_iss = 1'b1; rd_iss = 5'd12; dest_iss = 4'd5;
    flush = 1'b1;
    step();
    expect_read("rdy_low", 5'd11, 5'd12, 4'd3, 0, 0, 0);
    expect_read("rdy_low_x3", 5'd3, 5'd0, 0, 32'h22, 0, 0);

    // Randomized phase against the model, starting from a fresh async reset.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_tag[i] = '0;
    end
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) begin
      logic [TW-1:0]   eqj, eqk;
      logic [XLEN-1:0] evj, evk;
      exp_t e;
      rdy       = ($urandom_range(9) != 0);
      valid_iss = $urandom_range(1);
      rd_iss    = RW'($urandom_range(7));
      dest_iss  = TW'($urandom_range(15));
      rd_rob    = RW'($urandom_range(7));
      dest_rob  = ($urandom_range(2) != 0) ? m_tag[rd_rob] : TW'($urandom_range(15));
      if (!rdy) dest_rob = '0;
      val_rob   = $urandom;
      flush     = ($urandom_range(19) == 0);
      rs1       = RW'($urandom_range(7));
      rs2       = ($urandom_range(1) != 0) ? rd_rob : RW'($urandom_range(7));
      model_read(rs1, eqj, evj);
      model_read(rs2, eqk, evk);
      e.name = "rand"; e.qj = eqj; e.vj = evj; e.qk = eqk; e.vk = evk;
      exp_q.push_back(e);
      #1;
      compare_front();
      @(posedge clk);
      model_update();
      #1;
    end

    if (exp_q.size() != 0) check("scoreboard_leftover", XLEN'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags; sits directly downstream of the reorder buffer's commit port and beside the issuer.
- Holds 32 committed values plus, per register, the ROB entry id of the youngest in-flight producer (0 = no pending producer).
- Issuer reads operands as either a ready value or a ROB tag to wait on, and records new producers at issue.
- ROB commits write values and clear tags; the ROB flush clears all tags.

Parameters:
- XLEN, 32, data width of each register.
- REG_ID_WIDTH, 5, width of architectural register index; 2**REG_ID_WIDTH registers.
- ROB_ID_WIDTH, 4, width of ROB entry id; id 0 is reserved as "none".

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global ready; when low, no state changes.
- rs1_from_issuer  in  REG_ID_WIDTH  source register 1 index.
- rs2_from_issuer  in  REG_ID_WIDTH  source register 2 index.
- qj_to_issuer  out  ROB_ID_WIDTH  pending producer tag for rs1, 0 if value ready.
- vj_to_issuer  out  XLEN  rs1 value; valid only when qj_to_issuer == 0.
- qk_to_issuer  out  ROB_ID_WIDTH  pending producer tag for rs2.
- vk_to_issuer  out  XLEN  rs2 value.
- valid_from_issuer  in  1  an instruction with a destination issues this cycle.
- rd_from_issuer  in  REG_ID_WIDTH  destination register of issuing instruction.
- dest_from_issuer  in  ROB_ID_WIDTH  ROB id allocated to issuing instruction.
- dest_from_rob  in  ROB_ID_WIDTH  committing ROB id, 0 = no commit.
- rd_from_rob  in  REG_ID_WIDTH  committing destination register.
- value_from_rob  in  XLEN  committing value.
- reset_from_rob_bus  in  1  mispredict flush.

Behaviour:
- Reset (rst_n low, async): all values and all tags cleared to 0; read outputs therefore show q=0, v=0 for every index.
- Register 0: value and tag always 0; writes and issues to rd=0 are ignored. Reads of index 0 return q=0, v=0.
- Commit (rising edge, rdy high, dest_from_rob != 0, rd_from_rob != 0):
  - value[rd] <= value_from_rob.
  - If tag[rd] == dest_from_rob, tag[rd] <= 0; otherwise the tag is kept, because a younger producer exists.
- Issue (rising edge, rdy high, valid_from_issuer, rd_from_issuer != 0, no flush): tag[rd] <= dest_from_issuer.
- Same register committed and issued in the same cycle: the issue tag wins; the commit value is still written.
- Flush (reset_from_rob_bus high on a rising edge with rdy high):
  - All tags cleared to 0.
  - Issue in that cycle is discarded.
  - Commit in that cycle still writes its value, because the ROB presents the mispredicted branch's commit alongside the flush.
- rdy low: every register holds its state; reads stay combinational.
- Reads are combinational from current state, with zero latency. Base rule: q = tag[rs]; v = value[rs].
- Only tags are renamed; values are never speculative.

Optional Feature:
- Macro: REG_FILE_COMMIT_BYPASS_EN.
- Defined:
  - If a commit is presented this cycle with dest_from_rob != 0, rd_from_rob == rs != 0, and tag[rs] == dest_from_rob, the read port returns q=0 and v=value_from_rob in the same cycle.
  - Applies independently to both read ports.
- Undefined: reads return stored state only. The issuer sees the committed value one cycle later.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> qj=0, vj=0, qk=0, vk=0; write attempts to x0 leave x0 reading 0.
- Issue rd=3 with dest=7; next cycle read rs1=3 -> qj=7. Commit dest=7, rd=3, value=0xDEADBEEF; next cycle -> qj=0, vj=0xDEADBEEF.
- Issue rd=3 with dest=7, then rd=3 with dest=9; commit dest=7 value=0x11 -> value[3]=0x11 but qj stays 9. Commit dest=9 value=0x22 -> qj=0, vj=0x22.
- In one cycle, commit dest=4, rd=8, value=0x55 and issue rd=8 with dest=5 -> next cycle q=5; after commit of 5, value reflects the later commit.
- Tags set on x1=2, x2=3; pulse reset_from_rob_bus with commit dest=2, rd=1, value=0xAA and issue rd=6 with dest=4 -> x1 q=0 v=0xAA, x2 q=0, x6 q=0.
- Bypass: tag[10]=6; commit dest=6, rd=10, value=0x1234 while reading rs2=10.
  - With REG_FILE_COMMIT_BYPASS_EN: same cycle qk=0, vk=0x1234.
  - Without it: same cycle qk=6, then qk=0, vk=0x1234 next cycle.
  - With rdy low, no state change occurs.
